mmio_uart_transmitter: RTL and testbench

// - Memory-mapped UART transmitter on the data-memory store/load bus; the consumer end of the byte-wide console port.
// - CPU stores to TX_ADDRESS push a byte into a FIFO. The serializer emits each byte as 8N1 on uart_tx.
// - CPU loads from STATUS_ADDRESS return FIFO/serializer state. Backpressure uses clk_stall, which the pipeline ORs with the memory stall.

---
 rtl/mmio_uart_transmitter.sv | 194 +++++++++++++++++++
 tb/tb_mmio_uart_transmitter.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_uart_transmitter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mmio_uart_transmitter                                        |
// | Description : Memory-mapped 8N1 UART transmitter. Stores to TX_ADDRESS     |
// |               queue bytes in a circular FIFO; loads from STATUS_ADDRESS    |
// |               return busy/empty/full/count. clk_stall holds the pipeline   |
// |               while the FIFO is full.                                      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module mmio_uart_transmitter #(
  parameter int unsigned CLOCKS_PER_BIT  = 868,
  parameter int unsigned FIFO_DEPTH_LOG2 = 4,
  parameter logic [31:0] TX_ADDRESS      = 32'h2000,
  parameter logic [31:0] STATUS_ADDRESS  = 32'h2004
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        request_write,
  input  logic        request_read,
  input  logic [31:0] full_address,
  input  logic [31:0] write_data,
  output logic        clk_stall,
  output logic [31:0] read_data,
  output logic        uart_tx,
  output logic        tx_busy
);

  localparam int unsigned c_DEPTH  = 1 << FIFO_DEPTH_LOG2;
  localparam int unsigned c_CNT_W  = FIFO_DEPTH_LOG2 + 1;
  localparam int unsigned c_BAUD_W = $clog2(CLOCKS_PER_BIT);
  localparam logic [c_BAUD_W-1:0] c_BAUD_LAST  = c_BAUD_W'(CLOCKS_PER_BIT - 1);
  localparam logic [c_CNT_W-1:0]  c_FULL_COUNT = c_CNT_W'(c_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } tx_state_t;

  // FIFO storage and pointers
  logic [7:0]                 r_mem [c_DEPTH];
  logic [FIFO_DEPTH_LOG2-1:0] r_head;
  logic [FIFO_DEPTH_LOG2-1:0] r_tail;
  logic [c_CNT_W-1:0]         r_count;

  // Serializer state
  tx_state_t          r_state;
  tx_state_t          w_next_state;
  logic [c_BAUD_W-1:0] r_baud;
  logic [2:0]         r_bit_idx;
  logic [7:0]         r_shift;
  logic               r_uart_tx;
  logic [31:0]        r_read_data;

  logic        w_tx_hit;
  logic        w_status_hit;
  logic        w_empty;
  logic        w_full;
  logic        w_bit_end;
  logic        w_pop;
  logic        w_push;
  logic        w_tx_bit;
  logic        w_tx_busy;
  logic [31:0] w_status;

  // Only the low byte of a store carries transmit data.
  logic        w_unused_write_bits;
  assign w_unused_write_bits = ^write_data[31:8];

  assign w_tx_hit     = request_write && (full_address == TX_ADDRESS);
  // A simultaneous store wins the bus, so the status register is left alone.
  assign w_status_hit = request_read && !request_write && (full_address == STATUS_ADDRESS);
  assign w_empty      = (r_count == '0);
  assign w_full       = (r_count == c_FULL_COUNT);
  assign w_bit_end    = (r_baud == c_BAUD_LAST);

  // A pop frees a slot this very cycle, so a store to a full FIFO can still land.
  assign w_push    = w_tx_hit && (!w_full || w_pop);
  assign clk_stall = w_tx_hit && w_full && !w_pop;
  assign w_tx_busy = !w_empty || (r_state != S_IDLE);
  assign tx_busy   = w_tx_busy;
  assign uart_tx   = r_uart_tx;
  assign read_data = r_read_data;

  // Serializer next state, FIFO pop request and the line level for this bit.
  always_comb begin
    w_next_state = r_state;
    w_pop        = 1'b0;
    w_tx_bit     = 1'b1;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_pop        = 1'b1;
          w_next_state = S_START;
        end
      end
      S_START: begin
        w_tx_bit = 1'b0;
        if (w_bit_end) w_next_state = S_DATA;
      end
      S_DATA: begin
        w_tx_bit = r_shift[0];
        if (w_bit_end && (r_bit_idx == 3'd7)) w_next_state = S_STOP;
      end
      S_STOP: begin
        w_tx_bit = 1'b1;
        // Chaining straight into START keeps back-to-back frames gapless.
        if (w_bit_end) begin
          if (!w_empty) begin
            w_pop        = 1'b1;
            w_next_state = S_START;
          end else begin
            w_next_state = S_IDLE;
          end
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Status word assembled from the current FIFO and serializer state.
  always_comb begin
    w_status                  = '0;
    w_status[0]               = w_tx_busy;
    w_status[1]               = w_empty;
    w_status[2]               = w_full;
    w_status[3 +: c_CNT_W]    = r_count;
  end

  // Serializer state register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  // Baud counter, bit index and shift register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_baud    <= '0;
      r_bit_idx <= 3'd0;
      r_shift   <= 8'd0;
    end else if (w_pop) begin
      r_shift   <= r_mem[r_head];
      r_baud    <= '0;
      r_bit_idx <= 3'd0;
    end else if (r_state != S_IDLE) begin
      if (w_bit_end) begin
        r_baud <= '0;
        if (r_state == S_DATA) begin
          r_shift   <= r_shift >> 1;
          r_bit_idx <= r_bit_idx + 3'd1;
        end
      end else begin
        r_baud <= r_baud + c_BAUD_W'(1);
      end
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_tail <= r_tail + FIFO_DEPTH_LOG2'(1);
      if (w_pop)  r_head <= r_head + FIFO_DEPTH_LOG2'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_CNT_W'(1);
        2'b01:   r_count <= r_count - c_CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // FIFO data write; contents need no reset because the pointers gate them.
  always_ff @(posedge clk) begin
    if (!reset && w_push) r_mem[r_tail] <= write_data[7:0];
  end

  // Registered serial line and status read port.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_uart_tx   <= 1'b1;
      r_read_data <= 32'd0;
    end else begin
      r_uart_tx <= w_tx_bit;
      if (w_status_hit) r_read_data <= w_status;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mmio_uart_transmitter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_mmio_uart_transmitter                                     |
// | Description : Randomized bench for mmio_uart_transmitter with a frame-     |
// |               position reference model and literal pinned expectations.  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_mmio_uart_transmitter;

  localparam int          c_CPB    = 4;
  localparam int          c_DLOG   = 2;
  localparam int          c_DEPTH  = 1 << c_DLOG;
  localparam int          c_CNTW   = c_DLOG + 1;
  localparam int          c_FRAME  = 10 * c_CPB;
  localparam logic [31:0] c_TX     = 32'h2000;
  localparam logic [31:0] c_STATUS = 32'h2004;

  logic        clk;
  logic        reset;
  logic        request_write;
  logic        request_read;
  logic [31:0] full_address;
  logic [31:0] write_data;
  logic        clk_stall;
  logic [31:0] read_data;
  logic        uart_tx;
  logic        tx_busy;

  int checks = 0;
  int errors = 0;

  mmio_uart_transmitter #(
    .CLOCKS_PER_BIT (c_CPB),
    .FIFO_DEPTH_LOG2(c_DLOG),
    .TX_ADDRESS     (c_TX),
    .STATUS_ADDRESS (c_STATUS)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .request_write(request_write),
    .request_read (request_read),
    .full_address (full_address),
    .write_data   (write_data),
    .clk_stall    (clk_stall),
    .read_data    (read_data),
    .uart_tx      (uart_tx),
    .tx_busy      (tx_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Queue of waiting bytes, plus the byte on the wire and how many cycles
  // into its 10-bit frame we are (frame position counted from the pop edge).
  logic [7:0]  q[$];
  logic [7:0]  cur;
  bit          active = 1'b0;
  int          pos = 0;
  logic        tx_m = 1'b1;
  logic [31:0] rd_m = 32'd0;
  bit          model_valid = 1'b0;

  function automatic logic fbit(input logic [7:0] b, input int idx);
    if (idx == 0) return 1'b0;
    if (idx == 9) return 1'b1;
    return b[idx-1];
  endfunction

  function automatic bit pop_now();
    return (q.size() > 0) && (!active || pos == c_FRAME - 1);
  endfunction

  function automatic logic model_busy();
    return active || (q.size() > 0);
  endfunction

  function automatic logic exp_stall();
    return request_write && (full_address == c_TX) && (q.size() == c_DEPTH) && !pop_now();
  endfunction

  function automatic logic [31:0] status_word();
    logic [31:0] w;
    w                 = '0;
    w[0]              = model_busy();
    w[1]              = (q.size() == 0);
    w[2]              = (q.size() == c_DEPTH);
    w[3 +: c_CNTW]    = c_CNTW'(q.size());
    return w;
  endfunction

  always @(posedge clk) begin
    bit p;
    bit push;
    if (reset) begin
      q.delete();
      active      = 1'b0;
      pos         = 0;
      tx_m        = 1'b1;
      rd_m        = 32'd0;
      model_valid = 1'b1;
    end else begin
      p    = pop_now();
      push = request_write && (full_address == c_TX) && ((q.size() < c_DEPTH) || p);
      if (request_read && !request_write && full_address == c_STATUS) rd_m = status_word();
      tx_m = active ? fbit(cur, pos / c_CPB) : 1'b1;
      if (p) begin
        cur    = q.pop_front();
        active = 1'b1;
        pos    = 0;
      end else if (active) begin
        if (pos == c_FRAME - 1) active = 1'b0;
        else                    pos++;
      end
      if (push) q.push_back(write_data[7:0]);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (model_valid) begin
      chk("uart_tx",   {31'd0, uart_tx},   {31'd0, tx_m});
      chk("read_data", read_data,          rd_m);
      chk("tx_busy",   {31'd0, tx_busy},   {31'd0, model_busy()});
      chk("clk_stall", {31'd0, clk_stall}, {31'd0, exp_stall()});
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic idle_bus();
    request_write = 1'b0;
    request_read  = 1'b0;
    full_address  = $urandom;
    write_data    = $urandom;
  endtask

  // One bus transaction, held while the DUT stalls; returns stalled cycles.
  task automatic bus(input bit rw, input bit rr, input logic [31:0] a,
                     input logic [7:0] d, output int stalls);
    bit st;
    stalls          = 0;
    request_write   = rw;
    request_read    = rr;
    full_address    = a;
    write_data      = $urandom;
    write_data[7:0] = d;
    forever begin
      @(negedge clk);
      st = clk_stall;
      @(posedge clk);
      #1;
      if (!st) break;
      stalls++;
      if (stalls > 500) begin
        chk("stall_timeout", 32'(stalls), 32'd0);
        break;
      end
    end
    idle_bus();
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (tx_busy && n < 1000) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain", {31'd0, tx_busy}, 32'd0);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    int          st;
    logic [9:0]  pat_a5;
    logic        expb;
    int          op;
    logic [31:0] a;

    pat_a5 = 10'b1101001010;  // 0xA5 framed, index 0 is the start bit

    // Reset with random bus activity.
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      request_write = 1'($urandom);
      request_read  = 1'($urandom);
      full_address  = ($urandom_range(0, 1) == 1) ? c_TX : 32'($urandom);
      write_data    = $urandom;
      @(posedge clk);
      #1;
    end
    reset = 1'b0;
    idle_bus();
    @(negedge clk);
    chk("rst_uart_tx",   {31'd0, uart_tx},   32'd1);
    chk("rst_read_data", read_data,          32'd0);
    chk("rst_tx_busy",   {31'd0, tx_busy},   32'd0);
    chk("rst_clk_stall", {31'd0, clk_stall}, 32'd0);
    @(posedge clk);
    #1;

    // Single byte 0xA5: start bit two edges after the push edge.
    bus(1'b1, 1'b0, c_TX, 8'hA5, st);
    repeat (2) @(negedge clk);
    for (int i = 0; i < c_FRAME; i++) begin
      @(negedge clk);
      chk($sformatf("a5_sample%0d", i), {31'd0, uart_tx}, {31'd0, pat_a5[i / c_CPB]});
    end
    chk("a5_busy_after", {31'd0, tx_busy}, 32'd0);
    @(posedge clk);
    #1;
    drain();

    // Back-to-back 0x00 then 0xFF: 80 contiguous frame cycles.
    bus(1'b1, 1'b0, c_TX, 8'h00, st);
    bus(1'b1, 1'b0, c_TX, 8'hFF, st);
    @(negedge clk);
    for (int i = 0; i < 2 * c_FRAME; i++) begin
      @(negedge clk);
      expb = !((i < 36) || (i >= 40 && i < 44));
      chk($sformatf("b2b_sample%0d", i), {31'd0, uart_tx}, {31'd0, expb});
    end
    chk("b2b_busy_after", {31'd0, tx_busy}, 32'd0);
    @(posedge clk);
    #1;
    drain();

    // Six stores while idle: the sixth waits for the end of the first frame.
    for (int k = 0; k < 6; k++) begin
      bus(1'b1, 1'b0, c_TX, 8'(8'h10 + k), st);
      if (k == 5) chk("stall_cycles", 32'(st), 32'd36);
    end
    drain();

    // Status with three queued and a frame in progress.
    for (int k = 0; k < 4; k++) bus(1'b1, 1'b0, c_TX, 8'(8'hC0 + k), st);
    bus(1'b0, 1'b1, c_STATUS, 8'h00, st);
    chk("status_word", read_data, 32'h19);
    drain();

    // Reset during data bit 3 of the first frame.
    bus(1'b1, 1'b0, c_TX, 8'h37, st);
    bus(1'b1, 1'b0, c_TX, 8'h81, st);
    bus(1'b1, 1'b0, c_TX, 8'h42, st);
    repeat (16) begin
      @(posedge clk);
      #1;
    end
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("midrst_uart_tx",   {31'd0, uart_tx}, 32'd1);
    chk("midrst_tx_busy",   {31'd0, tx_busy}, 32'd0);
    chk("midrst_read_data", read_data,        32'd0);
    repeat (60) begin
      @(posedge clk);
      #1;
    end
    chk("midrst_quiet", {31'd0, uart_tx}, 32'd1);

    // Address filtering.
    bus(1'b0, 1'b1, c_STATUS, 8'h00, st);
    chk("idle_status", read_data, 32'h2);
    bus(1'b1, 1'b0, 32'h2008, 8'h55, st);
    chk("filter_no_push", {31'd0, tx_busy}, 32'd0);
    bus(1'b0, 1'b1, c_TX, 8'h00, st);
    chk("filter_no_read", read_data, 32'h2);

    // Randomized traffic.
    for (int n = 0; n < 500; n++) begin
      op = $urandom_range(0, 9);
      case (op)
        0, 1, 2: bus(1'b0, 1'b0, 32'($urandom), 8'($urandom), st);
        3, 4, 5: bus(1'b1, 1'b0, c_TX, 8'($urandom), st);
        6:       bus(1'b0, 1'b1, c_STATUS, 8'($urandom), st);
        7: begin
          a = ($urandom_range(0, 1) == 1) ? 32'h2008 : 32'($urandom);
          bus(1'b1, 1'b0, a, 8'($urandom), st);
        end
        8:       bus(1'b0, 1'b1, c_TX, 8'($urandom), st);
        default: begin
          a = ($urandom_range(0, 1) == 1) ? c_TX : c_STATUS;
          bus(1'b1, 1'b1, a, 8'($urandom), st);
        end
      endcase
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
